cache_system: RTL and testbench

Four-way set-associative, write-through, write-allocate cache with an integrated behavioural main memory. It sits between a single CPU port and the memory model. It serves single-word reads and writes through a request/ready handshake and uses true-LRU replacement per set. All control lives in an internal controller instance, `controller_inst`, which exposes `state` and `cache_hit` for hierarchical monitoring.

---
 rtl/cache_system.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cache_system.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_system.sv
// cache_system: 4-way set-associative write-through/write-allocate cache
// with true-LRU and a behavioural main memory. Option macro: CACHE_STATS_EN.

module cache_controller #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SETS    = 64,
  parameter int NUM_WAYS    = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] word_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic                  cpu_read_enable,
  input  logic                  cpu_write_enable,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_ready,
  output logic [ADDR_WIDTH-3:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    MEM_READ  = 2'd2,
    MEM_WRITE = 2'd3
  } state_t;

  state_t state;
  logic   cache_hit;

  logic                  valid [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      tags  [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]      age   [NUM_SETS][NUM_WAYS];

  logic [ADDR_WIDTH-3:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  is_write;
  logic [CNT_W-1:0]      cnt;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             last;
  logic             hit_any;
  logic             inv_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] old_way;
  logic [WAY_W-1:0] acc_way;
  logic [WAY_W-1:0] acc_age;
  logic [WAY_W-1:0] next_age [NUM_WAYS];
  logic             touch;
  logic             fill;
  logic [DATA_WIDTH-1:0] fill_data;

  assign idx  = addr_q[IDX_W-1:0];
  assign tag  = addr_q[ADDR_WIDTH-3:IDX_W];
  assign last = (cnt == CNT_W'(MEM_LATENCY - 1));

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_write      = (state == MEM_WRITE) && last;

  // Tag match, victim choice and the LRU ages after touching acc_way
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    old_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age[idx][w] == WAY_W'(NUM_WAYS - 1))
        old_way = WAY_W'(w);
    end
    acc_way = hit_any ? hit_way : (inv_any ? inv_way : old_way);
    acc_age = age[idx][acc_way];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == acc_way)
        next_age[w] = '0;
      else if (age[idx][w] < acc_age)
        next_age[w] = age[idx][w] + 1'b1;
      else
        next_age[w] = age[idx][w];
    end
  end

  assign cache_hit = (state == LOOKUP) && hit_any;

  assign fill = ((state == LOOKUP) && is_write) ||
                ((state == MEM_READ) && last);
  assign touch = fill || cache_hit;
  assign fill_data = is_write ? wdata_q : mem_read_data;

  // Valid bits and LRU ages, reset to empty with age[w] = w
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid[s][w] <= 1'b0;
          age[s][w]   <= WAY_W'(w);
        end
      end
    end else if (touch) begin
      for (int w = 0; w < NUM_WAYS; w++)
        age[idx][w] <= next_age[w];
      if (fill)
        valid[idx][acc_way] <= 1'b1;
    end
  end

  // Tag and data storage, written on allocation or write hit
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[idx][acc_way] <= tag;
      data[idx][acc_way] <= fill_data;
    end
  end

  // Controller FSM with registered ready and read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cpu_ready     <= 1'b1;
      cpu_read_data <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      is_write      <= 1'b0;
      cnt           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_write_enable || cpu_read_enable) begin
            addr_q    <= word_address;
            wdata_q   <= cpu_write_data;
            is_write  <= cpu_write_enable;
            cpu_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          cnt <= '0;
          if (is_write) begin
            state <= MEM_WRITE;
          end else if (hit_any) begin
            cpu_read_data <= data[idx][hit_way];
            cpu_ready     <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (last) begin
            cpu_read_data <= mem_read_data;
            cpu_ready     <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEM_WRITE: begin
          if (last) begin
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // One of the two counters advances on every lookup
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit_any)
        hit_count <= hit_count + 1'b1;
      else
        miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

module cache_system #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SETS    = 64,
  parameter int NUM_WAYS    = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic                  cpu_read_enable,
  input  logic                  cpu_write_enable,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_ready
);
  localparam int MEM_WORDS = 2 ** (ADDR_WIDTH - 2);

  logic [ADDR_WIDTH-3:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_write;
  logic                  unused_bits;

  // Memory holds each word XORed with its own address, so the
  // zeroed power-up image reads back as mem[i] = i; reset leaves it alone
  logic [DATA_WIDTH-1:0] mem_delta [MEM_WORDS];

  assign unused_bits   = ^cpu_address[1:0];
  assign mem_read_data = mem_delta[mem_address] ^ DATA_WIDTH'(mem_address);

  // Write-through port, driven on the last MEM_WRITE cycle
  always_ff @(posedge clk) begin
    if (mem_write)
      mem_delta[mem_address] <= mem_write_data ^ DATA_WIDTH'(mem_address);
  end

  cache_controller #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SETS   (NUM_SETS),
    .NUM_WAYS   (NUM_WAYS),
    .MEM_LATENCY(MEM_LATENCY)
  ) controller_inst (
    .clk             (clk),
    .rst             (rst),
    .word_address    (cpu_address[ADDR_WIDTH-1:2]),
    .cpu_write_data  (cpu_write_data),
    .cpu_read_enable (cpu_read_enable),
    .cpu_write_enable(cpu_write_enable),
    .cpu_read_data   (cpu_read_data),
    .cpu_ready       (cpu_ready),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_write       (mem_write),
    .mem_read_data   (mem_read_data)
  );

endmodule

// File: tb/tb_cache_system.sv
// tb_cache_system: randomized and directed checks of cache_system
// against an LRU-list and flat-memory reference model.

module tb_cache_system;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic        cpu_read_enable;
  logic        cpu_write_enable;
  logic [31:0] cpu_read_data;
  logic        cpu_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: MRU-first tag list per set, flat memory
  int          ord [64][4];
  int          cnt [64];
  logic [31:0] mem_m [16384];

  cache_system #(.MEM_LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_address     (cpu_address),
    .cpu_write_data  (cpu_write_data),
    .cpu_read_enable (cpu_read_enable),
    .cpu_write_enable(cpu_write_enable),
    .cpu_read_data   (cpu_read_data),
    .cpu_ready       (cpu_ready)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int s = 0; s < 64; s++) cnt[s] = 0;
  endtask

  task automatic model_op(input bit wr, input logic [15:0] a,
                          input logic [31:0] d, output bit h,
                          output logic [31:0] rd, output int e);
    int s;
    int t;
    int pos;
    s = int'(a[7:2]);
    t = int'(a[15:8]);
    pos = -1;
    for (int i = 0; i < cnt[s]; i++)
      if (ord[s][i] == t) pos = i;
    h = (pos >= 0);
    if (!h) begin
      if (cnt[s] < 4) cnt[s]++;
      pos = cnt[s] - 1;
    end
    for (int i = pos; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = t;
    if (wr) mem_m[a[15:2]] = d;
    rd = mem_m[a[15:2]];
    e = (!wr && h) ? 2 : 2 + LAT;
  endtask

  // one transaction; returns what the DUT showed
  task automatic access(input bit wr, input bit rd, input logic [15:0] a,
                        input logic [31:0] d, output int edges,
                        output logic hit, output logic [31:0] rdata,
                        output logic busy);
    @(negedge clk);
    cpu_address      = a;
    cpu_write_data   = d;
    cpu_read_enable  = rd;
    cpu_write_enable = wr;
    @(posedge clk);
    #1;
    edges = 1;
    hit   = dut.controller_inst.cache_hit;
    busy  = ~cpu_ready;
    @(negedge clk);
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (cpu_ready) break;
    end
    rdata = cpu_read_data;
  endtask

  // apply one op to both DUT and model, check hit / data / latency
  task automatic op_check(input string nm, input bit wr, input bit rd,
                          input logic [15:0] a, input logic [31:0] d);
    int e;
    int ee;
    logic h;
    logic bz;
    bit eh;
    logic [31:0] r;
    logic [31:0] er;
    model_op(wr, a, d, eh, er, ee);
    access(wr, rd, a, d, e, h, r, bz);
    n_cmp++;
    if (h !== eh) begin
      n_bad++;
      $display("FAIL %s hit @%h: got %b want %b", nm, a, h, eh);
    end
    n_cmp++;
    if (e !== ee) begin
      n_bad++;
      $display("FAIL %s latency @%h: got %0d want %0d", nm, a, e, ee);
    end
    n_cmp++;
    if (bz !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_low @%h: got %b want 1", nm, a, bz);
    end
    if (!wr) begin
      n_cmp++;
      if (r !== er) begin
        n_bad++;
        $display("FAIL %s data @%h: got %h want %h", nm, a, r, er);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (cpu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset ready: got %b want 1", cpu_ready);
    end
    n_cmp++;
    if (cpu_read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset rdata: got %h want 0", cpu_read_data);
    end
    n_cmp++;
    if (dut.controller_inst.state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset state: got %0d want 0",
               dut.controller_inst.state);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cpu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle ready: got %b want 1", cpu_ready);
    end
  endtask

  task automatic test_read_miss_hit();
    op_check("rd_miss", 1'b0, 1'b1, 16'h0004, 32'h0);
    op_check("rd_hit", 1'b0, 1'b1, 16'h0004, 32'h0);
    n_cmp++;
    if (cpu_read_data !== 32'h1) begin
      n_bad++;
      $display("FAIL rd0004 const: got %h want 00000001", cpu_read_data);
    end
  endtask

  task automatic test_write_read();
    op_check("wr100", 1'b1, 1'b0, 16'h0100, 32'hDEADBEEF);
    op_check("rd100", 1'b0, 1'b1, 16'h0100, 32'h0);
    op_check("ev0", 1'b0, 1'b1, 16'h0000, 32'h0);
    op_check("ev1", 1'b0, 1'b1, 16'h0200, 32'h0);
    op_check("ev2", 1'b0, 1'b1, 16'h0400, 32'h0);
    op_check("ev3", 1'b0, 1'b1, 16'h0500, 32'h0);
    op_check("mem40", 1'b0, 1'b1, 16'h0100, 32'h0);
    n_cmp++;
    if (cpu_read_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL mem40 const: got %h want deadbeef", cpu_read_data);
    end
  endtask

  task automatic test_lru_eviction();
    logic [15:0] a [4];
    a[0] = 16'h0010; a[1] = 16'h0410;
    a[2] = 16'h0810; a[3] = 16'h0C10;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        op_check("lru_fill", 1'b0, 1'b1, a[i], 32'h0);
    op_check("lru_evict", 1'b0, 1'b1, 16'h1010, 32'h0);
    op_check("lru_refetch", 1'b0, 1'b1, 16'h0010, 32'h0);
    n_cmp++;
    if (cpu_read_data !== 32'h4) begin
      n_bad++;
      $display("FAIL lru const: got %h want 00000004", cpu_read_data);
    end
  endtask

  task automatic test_write_through();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 32'hAAAAAAAA + 32'h11111111 * i;
      op_check("wt_wr", 1'b1, 1'b0, 16'(16'h0020 + 16'h0400 * i), v);
    end
    for (int i = 0; i < 4; i++)
      op_check("wt_rd", 1'b0, 1'b1, 16'(16'h0020 + 16'h0400 * i), 32'h0);
    op_check("wt_evict", 1'b1, 1'b0, 16'h1020, 32'hEEEEEEEE);
    op_check("wt_back", 1'b0, 1'b1, 16'h0020, 32'h0);
    n_cmp++;
    if (cpu_read_data !== 32'hAAAAAAAA) begin
      n_bad++;
      $display("FAIL wt const: got %h want aaaaaaaa", cpu_read_data);
    end
  endtask

  task automatic test_both_enables();
    op_check("both", 1'b1, 1'b1, 16'h0300, 32'hA5A5A5A5);
    op_check("both_rd", 1'b0, 1'b1, 16'h0300, 32'h0);
    n_cmp++;
    if (cpu_read_data !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL both const: got %h want a5a5a5a5", cpu_read_data);
    end
  endtask

  // enables held while busy must not start or queue anything
  task automatic test_ignored_enables();
    bit eh;
    int ee;
    logic [31:0] er;
    bit done;
    model_op(1'b0, 16'h3A40, 32'h0, eh, er, ee);
    @(negedge clk);
    cpu_address     = 16'h3A40;
    cpu_read_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b1;
    cpu_address      = 16'h3B40;
    cpu_write_data   = 32'h12345678;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      if (cpu_ready) done = 1'b1;
    end
    @(negedge clk);
    cpu_write_enable = 1'b0;
    n_cmp++;
    if (!done || cpu_read_data !== er) begin
      n_bad++;
      $display("FAIL busy_read: got %h want %h", cpu_read_data, er);
    end
    op_check("not_queued", 1'b0, 1'b1, 16'h3B40, 32'h0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    cpu_address     = 16'h2270;
    cpu_read_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_read_enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dut.controller_inst.state == 2'd2) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL mid_memread: got none want state 2");
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cpu_ready !== 1'b1 || dut.controller_inst.state !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got ready %b state %0d want 1 0",
               cpu_ready, dut.controller_inst.state);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    op_check("post_reset", 1'b0, 1'b1, 16'h2270, 32'h0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    bit wr;
    for (int k = 0; k < 150; k++) begin
      a = {5'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
           6'($urandom_range(0, 2)), 2'($urandom)};
      wr = ($urandom_range(0, 2) == 0);
      op_check("rand", wr, !wr, a, $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem_m[i] = 32'(i);
    rst              = 1'b1;
    cpu_address      = '0;
    cpu_write_data   = '0;
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b0;
    #2;
    test_reset();
    test_read_miss_hit();
    test_write_read();
    test_lru_eviction();
    test_write_through();
    test_both_enables();
    test_ignored_enables();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
